// File: rtl/knn_rd_ctrl.sv
// KNN result read-back: buffers K words pushed by the core and serves one per CPU read.
// Reads acknowledge one cycle after acceptance; pushes are refused (and flagged) outside IDLE/FILL.
module knn_rd_ctrl #(
  parameter int DATA_W = 32,
  parameter int K      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready,
  input  logic              valid,
  input  logic              wstrb,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_done,
  output logic              busy,
  output logic              overflow
);
  localparam int CNT_W = $clog2(K + 1);
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {IDLE, FILL, SERVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ready_q, ready_d;
  logic              rd_done_q, rd_done_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic              push, drop, rd_acc;

  assign res_ready = en && (state_q == IDLE || state_q == FILL);
  assign push      = res_valid && res_ready && !clear;
  assign drop      = res_valid && en && !res_ready;
  // The !ready_q term keeps a CPU that holds valid through the ack from triggering a second read.
  assign rd_acc    = en && valid && !wstrb && !ready_q;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    ready_d    = rd_acc;
    rd_done_d  = 1'b0;
    ovf_d      = ovf_q;
    rdata_d    = rdata_q;
    if (rd_acc) rdata_d = '0;
    if (en) begin
      if (drop) ovf_d = 1'b1;
      if (clear) begin
        state_d    = IDLE;
        fill_cnt_d = '0;
        rd_ptr_d   = '0;
        ovf_d      = 1'b0;
      end else begin
        case (state_q)
          IDLE, FILL: begin
            if (push) begin
              fill_cnt_d = fill_cnt_q + CNT_W'(1);
              state_d    = (fill_cnt_q == LAST) ? SERVE : FILL;
            end
          end
          SERVE: begin
            if (rd_acc) begin
              rdata_d  = mem_q[rd_ptr_q[IDX_W-1:0]];
              rd_ptr_d = rd_ptr_q + CNT_W'(1);
              if (rd_ptr_q == LAST) state_d = DONE;
            end
          end
          DONE: begin
            rd_done_d  = 1'b1;
            fill_cnt_d = '0;
            rd_ptr_d   = '0;
            state_d    = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
    end
  end

  // Buffer contents need no reset: entries are always written before SERVE reads them.
  always_ff @(posedge clk) begin
    if (push) mem_q[fill_cnt_q[IDX_W-1:0]] <= res_data;
  end

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign rd_done  = rd_done_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_knn_rd_ctrl.sv
// Scoreboard bench for knn_rd_ctrl: expected read data queued at request, checked when ready rises.
`timescale 1ns/1ps
module tb_knn_rd_ctrl;
  localparam int DATA_W = 32;
  localparam int K      = 4;

  logic              clk = 1'b0;
  logic              rst, en, clear, res_valid, valid, wstrb;
  logic [DATA_W-1:0] res_data, rdata;
  logic              res_ready, ready, rd_done, busy, overflow;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  knn_rd_ctrl #(.DATA_W(DATA_W), .K(K)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .valid(valid), .wstrb(wstrb), .ready(ready), .rdata(rdata),
    .rd_done(rd_done), .busy(busy), .overflow(overflow)
  );

  // Every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    logic [DATA_W-1:0] e;
    if (rst && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: ready=1 rdata=%h with no read outstanding", rdata);
      end else begin
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL read_data: rdata=%h expected %h", rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    res_valid = 1'b1;
    res_data  = d;
    step();
    res_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [DATA_W-1:0] e, input string name);
    int n;
    if (ready) step();
    exp_q.push_back(e);
    valid = 1'b1;
    wstrb = 1'b0;
    n = 0;
    step();
    while (!ready && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!ready || n != 0) begin
      errors++;
      $display("FAIL %s_latency: ready=%0b after %0d extra cycles, expected ready 1 cycle after request", name, ready, n);
    end
    valid = 1'b0;
  endtask

  task automatic finish_set();
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clear = 1'b0; res_valid = 1'b0; res_data = '0;
    valid = 1'b0; wstrb = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    checks++;
    if ({ready, rd_done, busy, overflow} !== 4'b0000 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready/rd_done/busy/ovf=%b rdata=%h expected 0000 and 0", {ready, rd_done, busy, overflow}, rdata);
    end
    rst = 1'b1;
    step();
    checks++;
    if (res_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: res_ready=%b busy=%b expected 1 0", res_ready, busy);
    end
  endtask

  task automatic test_fill_and_read();
    for (int i = 0; i < K; i++) begin
      checks++;
      if (res_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_res_ready: push %0d res_ready=%b expected 1", i, res_ready);
      end
      push_word(32'h11 * (i + 1));
    end
    checks++;
    if (res_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: res_ready=%b busy=%b expected 0 1", res_ready, busy);
    end
    for (int i = 0; i < K; i++) cpu_read(32'h11 * (i + 1), "fill_read");
    checks++;
    if (rd_done !== 1'b0) begin
      errors++;
      $display("FAIL done_early: rd_done=%b in last ready cycle expected 0", rd_done);
    end
    step();
    checks++;
    if (rd_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: rd_done=%b busy=%b expected 1 0", rd_done, busy);
    end
    step();
    checks++;
    if (rd_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: rd_done=%b expected 0 after one cycle", rd_done);
    end
  endtask

  task automatic test_idle_read();
    exp_q.push_back('0);
    valid = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack: ready=%b expected 1", ready);
    end
    step();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_single_ack: ready=%b with valid held expected 0", ready);
    end
    valid = 1'b0;
    step();
    checks++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: ready=%b busy=%b expected 0 0", ready, busy);
    end
    valid = 1'b1; wstrb = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL write_ignored: ready=%b busy=%b expected 0 0", ready, busy);
      end
    end
    valid = 1'b0; wstrb = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < K; i++) push_word(32'hA0 + i);
    push_word(32'hFF);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b expected 1", overflow);
    end
    for (int i = 0; i < K; i++) cpu_read(32'hA0 + i, "ovf_read");
    finish_set();
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b busy=%b expected 1 0", overflow, busy);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
    end
  endtask

  task automatic test_clear_abort();
    push_word(32'h1);
    push_word(32'h2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: busy=%b expected 1", busy);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: busy=%b res_ready=%b expected 0 1", busy, res_ready);
    end
    for (int i = 0; i < K; i++) push_word(32'h5 + i);
    for (int i = 0; i < K; i++) cpu_read(32'h5 + i, "abort_read");
    finish_set();
  endtask

  task automatic test_collide();
    push_word(32'hC0);
    exp_q.push_back('0);
    res_valid = 1'b1; res_data = 32'hC1; valid = 1'b1;
    step();
    valid = 1'b0;
    push_word(32'hC2);
    exp_q.push_back('0);
    res_valid = 1'b1; res_data = 32'hC3; valid = 1'b1;
    step();
    res_valid = 1'b0; valid = 1'b0;
    checks++;
    if (ready !== 1'b1 || res_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_fill: ready=%b res_ready=%b busy=%b expected 1 0 1", ready, res_ready, busy);
    end
    for (int i = 0; i < K; i++) cpu_read(32'hC0 + i, "collide_read");
    finish_set();
  endtask

  task automatic test_en_freeze();
    for (int i = 0; i < K; i++) push_word(32'hB0 + i);
    cpu_read(32'hB0, "freeze_first");
    en = 1'b0; valid = 1'b1; wstrb = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold: ready=%b busy=%b expected 0 1", ready, busy);
      end
    end
    en = 1'b1;
    for (int i = 1; i < K; i++) cpu_read(32'hB0 + i, "freeze_resume");
    finish_set();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < K; i++) push_word(32'hD0 + i);
    valid = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: ready=%b expected 1 before reset", ready);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ready, rd_done, busy, overflow} !== 4'b0000 || rdata !== '0) begin
      errors++;
      $display("FAIL midrst_async: ready/rd_done/busy/ovf=%b rdata=%h expected 0000 and 0", {ready, rd_done, busy, overflow}, rdata);
    end
    valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    cpu_read('0, "midrst_read");
    step();
  endtask

  initial begin
    test_reset();
    test_fill_and_read();
    test_idle_read();
    test_overflow();
    test_clear_abort();
    test_collide();
    test_en_freeze();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads never acknowledged, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
